// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder: config-register
// offsets, the registered read-source select, and the byte-enable merge.
package data_sram_resp_pkg;

  localparam logic [15:0] CONF_LED   = 16'h0000;
  localparam logic [15:0] CONF_NUM   = 16'h0004;
  localparam logic [15:0] CONF_SW    = 16'h0008;
  localparam logic [15:0] CONF_TIMER = 16'h000C;

  // SEL_NONE only exists between reset and the first request, so rdata reads 0.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_CONF = 2'd2
  } sel_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_resp_conf_regs.sv
// Memory-mapped config block: LED, 7-seg number, switch sampling and a
// free-running timer, with a combinational read mux for the responder.
module conf_regs
  import data_sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [15:0] offset,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  input  logic [15:0] switch_in,
  output logic [31:0] rd_data,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic [31:0] timer
);

  logic [31:0] led_merged;
  logic [31:0] num_merged;
  logic [31:0] timer_merged;

  assign led_merged   = byte_merge({16'b0, led}, wdata, wen);
  assign num_merged   = byte_merge(num, wdata, wen);
  assign timer_merged = byte_merge(timer, wdata, wen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led   <= '0;
      num   <= '0;
      timer <= '0;
    end else begin
      if (wr && offset == CONF_LED) led <= led_merged[15:0];
      if (wr && offset == CONF_NUM) num <= num_merged;
      // A timer write replaces this cycle's increment; unwritten bytes hold.
      if (wr && offset == CONF_TIMER) timer <= timer_merged;
      else                            timer <= timer + 32'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      CONF_LED:   rd_data = {16'b0, led};
      CONF_NUM:   rd_data = num;
      CONF_SW:    rd_data = {16'b0, switch_in};
      CONF_TIMER: rd_data = timer;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/data_sram_resp.sv
// Responder end of the core's data SRAM port: word RAM plus config block,
// read-first, one-cycle read latency, no wait states.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out,
  output logic [31:0] timer_out
);

  // Request protocol: en=1 is a request accepted unconditionally at that
  // edge (no ready); wen!=0 writes enabled bytes; rdata always returns the
  // pre-edge content one cycle later and holds while en=0.
  localparam logic [15:0] CONF_HI = CONF_BASE[31:16];

  logic [31:0]       mem [1 << ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              conf_hit;
  logic              conf_wr;
  logic [31:0]       conf_rd;
  logic [31:0]       ram_q;
  logic [31:0]       conf_q;
  sel_t              sel_q;

  assign idx      = data_sram_addr[ADDR_W+1:2];
  assign conf_hit = (data_sram_addr[31:16] == CONF_HI);
  assign conf_wr  = data_sram_en && conf_hit && (data_sram_wen != 4'b0);

  conf_regs u_conf_regs (
    .clk       (clk),
    .rst       (rst),
    .wr        (conf_wr),
    .offset    (data_sram_addr[15:0]),
    .wen       (data_sram_wen),
    .wdata     (data_sram_wdata),
    .switch_in (switch_in),
    .rd_data   (conf_rd),
    .led       (led_out),
    .num       (num_out),
    .timer     (timer_out)
  );

  // RAM has no reset so it maps onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    if (data_sram_en && !conf_hit) begin
      ram_q <= mem[idx];
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= SEL_NONE;
      conf_q <= '0;
    end else if (data_sram_en) begin
      sel_q <= conf_hit ? SEL_CONF : SEL_RAM;
      if (conf_hit) conf_q <= conf_rd;
    end
  end

  always_comb begin
    data_sram_rdata = '0;
    case (sel_q)
      SEL_RAM:  data_sram_rdata = ram_q;
      SEL_CONF: data_sram_rdata = conf_q;
      default:  data_sram_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: table of RAM/config requests plus
// hand-written timer, hold and reset sequences, checked through a queue.
module tb_data_sram_resp;

  localparam logic [31:0] CONF = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch_in = 16'h0;
  logic [15:0] led_out;
  logic [31:0] num_out;
  logic [31:0] timer_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  data_sram_resp dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .num_out         (num_out),
    .timer_out       (timer_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one request per cycle; expected rdata is queued on drive and
  // compared just after the capturing edge
  task automatic do_req(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit chk,
                        input logic [31:0] exp, input string name);
    @(negedge clk);
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    while (exp_q.size() > 0) begin
      check(name_q.pop_front(), data_sram_rdata, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{4'h2, 32'h0000_0010, 32'h0000_AA00, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_AAEF};
    vecs[4]  = '{4'hF, 32'h0000_0020, 32'h0000_0001, 1'b0, 32'h0};
    vecs[5]  = '{4'hF, 32'h0000_0020, 32'h0000_0002, 1'b1, 32'h0000_0001};
    vecs[6]  = '{4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_0002};
    vecs[7]  = '{4'hF, 32'h0000_0024, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[8]  = '{4'h0, 32'h0000_4024, 32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{4'hF, CONF + 32'h4,  32'h1234_5678, 1'b1, 32'h0};
    vecs[10] = '{4'h8, CONF + 32'h4,  32'hAB00_0000, 1'b1, 32'h1234_5678};
    vecs[11] = '{4'h0, CONF + 32'h4,  32'h0,         1'b1, 32'hAB34_5678};
    vecs[12] = '{4'hF, CONF + 32'h0,  32'hABCD_1234, 1'b1, 32'h0};
    vecs[13] = '{4'h0, CONF + 32'h0,  32'h0,         1'b1, 32'h0000_1234};
    vecs[14] = '{4'hF, CONF + 32'h40, 32'h7777_7777, 1'b1, 32'h0};
    vecs[15] = '{4'h0, CONF + 32'h40, 32'h0,         1'b1, 32'h0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_timer", timer_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("idle_rdata", data_sram_rdata, 32'h0);
    check("idle_led", {16'h0, led_out}, 32'h0);
    check("idle_num", num_out, 32'h0);
    check("idle_timer", timer_out, 32'd5);

    // table-driven RAM and config traffic, back to back
    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp,
             $sformatf("vec%0d", i));
    end
    check("led_out", {16'h0, led_out}, 32'h0000_1234);
    check("num_out", num_out, 32'hAB34_5678);

    // switch register: writes ignored, rdata holds while en=0
    switch_in = 16'h5A5A;
    do_req(4'hF, CONF + 32'h8, 32'hFFFF_FFFF, 1'b0, 32'h0, "sw_wr");
    do_req(4'h0, CONF + 32'h8, 32'h0, 1'b1, 32'h0000_5A5A, "sw_rd");
    idle(2);
    check("hold_rdata", data_sram_rdata, 32'h0000_5A5A);

    // timer write, read-before-increment, wrap
    do_req(4'hF, CONF + 32'hC, 32'hFFFF_FFFE, 1'b0, 32'h0, "tmr_wr");
    check("tmr_after_wr", timer_out, 32'hFFFF_FFFE);
    do_req(4'h0, CONF + 32'hC, 32'h0, 1'b1, 32'hFFFF_FFFE, "tmr_rd0");
    do_req(4'h0, CONF + 32'hC, 32'h0, 1'b1, 32'hFFFF_FFFF, "tmr_rd1");
    do_req(4'h0, CONF + 32'hC, 32'h0, 1'b1, 32'h0000_0000, "tmr_wrap");
    check("tmr_after_wrap", timer_out, 32'h0000_0001);
    // partial write keeps the un-incremented upper bytes
    do_req(4'h1, CONF + 32'hC, 32'h1234_56AA, 1'b1, 32'h0000_0001, "tmr_pwr");
    check("tmr_partial", timer_out, 32'h0000_00AA);

    // reset while a read result is pending
    do_req(4'h0, CONF + 32'h4, 32'h0, 1'b1, 32'hAB34_5678, "pre_rst_rd");
    rst = 1'b1;
    #1;
    check("rst_mid_rdata", data_sram_rdata, 32'h0);
    check("rst_mid_led", {16'h0, led_out}, 32'h0);
    check("rst_mid_num", num_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_req(4'h0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_AAEF, "ram_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
